// File: rtl/mem_port_arbiter.sv
// Two-requester (I/D) arbiter for one shared memory port, with a registered request output,
// starvation guard for I, and an in-order read-ID FIFO that steers responses back.
module mem_port_arbiter #(
   parameter int unsigned AW              = 32,
   parameter int unsigned DW              = 32,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned STARVE_LIMIT    = 4
) (
   input  logic          clk,
   input  logic          reset,

   input  logic          i_req_valid,
   input  logic [AW-1:0] i_req_addr,
   input  logic [3:0]    i_req_do_read,
   output logic          i_req_ack,
   output logic          i_rsp_valid,
   output logic [DW-1:0] i_rsp_data,

   input  logic          d_req_valid,
   input  logic [AW-1:0] d_req_addr,
   input  logic [DW-1:0] d_req_data,
   input  logic [3:0]    d_req_do_read,
   input  logic [3:0]    d_req_do_write,
   output logic          d_req_ack,
   output logic          d_rsp_valid,
   output logic [DW-1:0] d_rsp_data,

   output logic          m_req_valid,
   output logic [AW-1:0] m_req_addr,
   output logic [DW-1:0] m_req_data,
   output logic [3:0]    m_req_do_read,
   output logic [3:0]    m_req_do_write,
   input  logic          m_req_ready,
   input  logic          m_rsp_valid,
   input  logic [DW-1:0] m_rsp_data,

   output logic          err_unexpected_rsp
);

   localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {
      SRC_I = 1'b0,
      SRC_D = 1'b1
   } src_t;

   // Output register
   logic          out_valid;
   logic [AW-1:0] out_addr;
   logic [DW-1:0] out_data;
   logic [3:0]    out_rd;
   logic [3:0]    out_wr;

   // Read-ID FIFO
   src_t          fifo_mem [MAX_OUTSTANDING];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] fifo_cnt;

   logic [SW-1:0] starve_cnt;
   logic          err_q;

   logic          capture_ok;
   logic          rsp_pop;
   logic          fifo_full;
   logic          i_is_read;
   logic          d_is_read;
   logic          i_elig;
   logic          d_elig;
   logic          i_grant;
   logic          d_grant;
   logic          enq;
   src_t          enq_src;
   src_t          head_src;

   assign rsp_pop    = m_rsp_valid && (fifo_cnt != '0);
   // A response popping this cycle frees a slot for a read granted in the same cycle.
   assign fifo_full  = (fifo_cnt == CW'(MAX_OUTSTANDING)) && !rsp_pop;
   assign i_is_read  = |i_req_do_read;
   assign d_is_read  = |d_req_do_read;
   assign i_elig     = i_req_valid && !(i_is_read && fifo_full);
   assign d_elig     = d_req_valid && !(d_is_read && fifo_full);
   assign capture_ok = reset && (!out_valid || m_req_ready);

   always_comb begin
      i_grant = 1'b0;
      d_grant = 1'b0;
      if (capture_ok) begin
         if (i_elig && d_elig && (starve_cnt == SW'(STARVE_LIMIT))) begin
            i_grant = 1'b1;
         end else if (d_elig) begin
            d_grant = 1'b1;
         end else if (i_elig) begin
            i_grant = 1'b1;
         end
      end
   end

   assign enq     = (i_grant && i_is_read) || (d_grant && d_is_read);
   assign enq_src = d_grant ? SRC_D : SRC_I;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_data  <= '0;
         out_rd    <= '0;
         out_wr    <= '0;
      end else if (i_grant) begin
         out_valid <= 1'b1;
         out_addr  <= i_req_addr;
         out_data  <= '0;
         out_rd    <= i_req_do_read;
         out_wr    <= '0;
      end else if (d_grant) begin
         out_valid <= 1'b1;
         out_addr  <= d_req_addr;
         out_data  <= d_req_data;
         out_rd    <= d_req_do_read;
         out_wr    <= d_req_do_write;
      end else if (out_valid && m_req_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned k = 0; k < MAX_OUTSTANDING; k++) begin
            fifo_mem[k] <= SRC_I;
         end
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (enq) begin
            fifo_mem[wr_ptr] <= enq_src;
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (rsp_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({enq, rsp_pop})
            2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= '0;
      end else if (!i_req_valid || i_grant) begin
         starve_cnt <= '0;
      end else if (d_grant && (starve_cnt != SW'(STARVE_LIMIT))) begin
         starve_cnt <= starve_cnt + SW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else if (m_rsp_valid && (fifo_cnt == '0)) begin
         err_q <= 1'b1;
      end
   end

   assign head_src = fifo_mem[rd_ptr];

   assign i_req_ack   = i_grant;
   assign d_req_ack   = d_grant;
   assign i_rsp_valid = rsp_pop && (head_src == SRC_I);
   assign d_rsp_valid = rsp_pop && (head_src == SRC_D);
   assign i_rsp_data  = i_rsp_valid ? m_rsp_data : '0;
   assign d_rsp_data  = d_rsp_valid ? m_rsp_data : '0;

   assign m_req_valid    = out_valid;
   assign m_req_addr     = out_addr;
   assign m_req_data     = out_data;
   assign m_req_do_read  = out_rd;
   assign m_req_do_write = out_wr;

   assign err_unexpected_rsp = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter: one vector per clock cycle, inputs driven
// on the falling edge and all outputs compared 1 time unit later.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req_valid;
   logic [31:0] i_req_addr;
   logic [3:0]  i_req_do_read;
   logic        i_req_ack;
   logic        i_rsp_valid;
   logic [31:0] i_rsp_data;
   logic        d_req_valid;
   logic [31:0] d_req_addr;
   logic [31:0] d_req_data;
   logic [3:0]  d_req_do_read;
   logic [3:0]  d_req_do_write;
   logic        d_req_ack;
   logic        d_rsp_valid;
   logic [31:0] d_rsp_data;
   logic        m_req_valid;
   logic [31:0] m_req_addr;
   logic [31:0] m_req_data;
   logic [3:0]  m_req_do_read;
   logic [3:0]  m_req_do_write;
   logic        m_req_ready;
   logic        m_rsp_valid;
   logic [31:0] m_rsp_data;
   logic        err_unexpected_rsp;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .AW(32), .DW(32), .MAX_OUTSTANDING(4), .STARVE_LIMIT(4)
   ) dut (
      .clk(clk), .reset(rst_n),
      .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_do_read(i_req_do_read),
      .i_req_ack(i_req_ack), .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
      .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_data(d_req_data),
      .d_req_do_read(d_req_do_read), .d_req_do_write(d_req_do_write),
      .d_req_ack(d_req_ack), .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
      .m_req_valid(m_req_valid), .m_req_addr(m_req_addr), .m_req_data(m_req_data),
      .m_req_do_read(m_req_do_read), .m_req_do_write(m_req_do_write),
      .m_req_ready(m_req_ready), .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data),
      .err_unexpected_rsp(err_unexpected_rsp)
   );

   typedef struct {
      logic        i_v;
      logic [31:0] i_a;
      logic [3:0]  i_rd;
      logic        d_v;
      logic [31:0] d_a;
      logic [31:0] d_dat;
      logic [3:0]  d_rd;
      logic [3:0]  d_wr;
      logic        m_rdy;
      logic        r_v;
      logic [31:0] r_dat;
      logic        e_iack;
      logic        e_dack;
      logic        e_mv;
      logic [31:0] e_ma;
      logic [31:0] e_md;
      logic [3:0]  e_mrd;
      logic [3:0]  e_mwr;
      logic        e_irsp;
      logic        e_drsp;
      logic [31:0] e_rdat;
      logic        e_err;
   } vec_t;

   function automatic vec_t nop();
      vec_t v;
      v = '{default: '0};
      v.m_rdy = 1'b1;
      return v;
   endfunction

   task automatic chk(input string tag, input string f, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s %s got=%h want=%h", tag, f, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      i_req_valid    = v.i_v;
      i_req_addr     = v.i_a;
      i_req_do_read  = v.i_rd;
      d_req_valid    = v.d_v;
      d_req_addr     = v.d_a;
      d_req_data     = v.d_dat;
      d_req_do_read  = v.d_rd;
      d_req_do_write = v.d_wr;
      m_req_ready    = v.m_rdy;
      m_rsp_valid    = v.r_v;
      m_rsp_data     = v.r_dat;
   endtask

   task automatic compare(input vec_t v, input string tag);
      chk(tag, "i_req_ack", 32'(i_req_ack), 32'(v.e_iack));
      chk(tag, "d_req_ack", 32'(d_req_ack), 32'(v.e_dack));
      chk(tag, "m_req_valid", 32'(m_req_valid), 32'(v.e_mv));
      chk(tag, "i_rsp_valid", 32'(i_rsp_valid), 32'(v.e_irsp));
      chk(tag, "d_rsp_valid", 32'(d_rsp_valid), 32'(v.e_drsp));
      chk(tag, "err", 32'(err_unexpected_rsp), 32'(v.e_err));
      if (v.e_mv) begin
         chk(tag, "m_req_addr", m_req_addr, v.e_ma);
         chk(tag, "m_req_data", m_req_data, v.e_md);
         chk(tag, "m_req_do_read", 32'(m_req_do_read), 32'(v.e_mrd));
         chk(tag, "m_req_do_write", 32'(m_req_do_write), 32'(v.e_mwr));
      end
      if (v.e_irsp) chk(tag, "i_rsp_data", i_rsp_data, v.e_rdat);
      if (v.e_drsp) chk(tag, "d_rsp_data", d_rsp_data, v.e_rdat);
   endtask

   task automatic run(input vec_t v, input string tag);
      @(negedge clk);
      drive(v);
      #1;
      compare(v, tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[12];
      vec_t v;
      logic        prev_i;
      logic [31:0] prev_da;
      logic [31:0] prev_dd;

      // Single I read, then interleaved I read / D read / D write / I read with in-order responses.
      tbl[0]  = nop(); tbl[0].i_v = 1; tbl[0].i_a = 32'h100; tbl[0].i_rd = 4'hF; tbl[0].e_iack = 1;
      tbl[1]  = nop(); tbl[1].e_mv = 1; tbl[1].e_ma = 32'h100; tbl[1].e_mrd = 4'hF;
      tbl[2]  = nop();
      tbl[3]  = nop(); tbl[3].r_v = 1; tbl[3].r_dat = 32'hDEADBEEF; tbl[3].e_irsp = 1; tbl[3].e_rdat = 32'hDEADBEEF;
      tbl[4]  = nop(); tbl[4].i_v = 1; tbl[4].i_a = 32'h10; tbl[4].i_rd = 4'hF; tbl[4].e_iack = 1;
      tbl[5]  = nop(); tbl[5].d_v = 1; tbl[5].d_a = 32'h20; tbl[5].d_rd = 4'h3; tbl[5].e_dack = 1;
      tbl[5].e_mv = 1; tbl[5].e_ma = 32'h10; tbl[5].e_mrd = 4'hF;
      tbl[6]  = nop(); tbl[6].d_v = 1; tbl[6].d_a = 32'h30; tbl[6].d_dat = 32'h55; tbl[6].d_wr = 4'hF; tbl[6].e_dack = 1;
      tbl[6].e_mv = 1; tbl[6].e_ma = 32'h20; tbl[6].e_mrd = 4'h3;
      tbl[7]  = nop(); tbl[7].i_v = 1; tbl[7].i_a = 32'h40; tbl[7].i_rd = 4'hF; tbl[7].e_iack = 1;
      tbl[7].e_mv = 1; tbl[7].e_ma = 32'h30; tbl[7].e_md = 32'h55; tbl[7].e_mwr = 4'hF;
      tbl[8]  = nop(); tbl[8].r_v = 1; tbl[8].r_dat = 32'h11111111; tbl[8].e_irsp = 1; tbl[8].e_rdat = 32'h11111111;
      tbl[8].e_mv = 1; tbl[8].e_ma = 32'h40; tbl[8].e_mrd = 4'hF;
      tbl[9]  = nop(); tbl[9].r_v = 1; tbl[9].r_dat = 32'h22222222; tbl[9].e_drsp = 1; tbl[9].e_rdat = 32'h22222222;
      tbl[10] = nop(); tbl[10].r_v = 1; tbl[10].r_dat = 32'h33333333; tbl[10].e_irsp = 1; tbl[10].e_rdat = 32'h33333333;
      tbl[11] = nop();

      rst_n = 1'b0;
      drive(nop());
      #12;
      compare(nop(), "reset");
      chk("reset", "m_req_addr", m_req_addr, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) run(tbl[i], $sformatf("tbl[%0d]", i));

      // I and D contending: D writes, I reads; expect D,D,D,D,I,D,D,D,D,I.
      prev_i = 1'b0; prev_da = '0; prev_dd = '0;
      for (int k = 0; k < 10; k++) begin
         v = nop();
         v.i_v = 1; v.i_a = 32'hA00; v.i_rd = 4'hF;
         v.d_v = 1; v.d_a = 32'hB00 + 32'(k * 4); v.d_dat = 32'(k); v.d_wr = 4'hF;
         v.e_iack = (k == 4 || k == 9);
         v.e_dack = !v.e_iack;
         v.e_mv = (k > 0);
         if (prev_i) begin
            v.e_ma = 32'hA00; v.e_mrd = 4'hF;
         end else begin
            v.e_ma = prev_da; v.e_md = prev_dd; v.e_mwr = 4'hF;
         end
         run(v, $sformatf("starve[%0d]", k));
         prev_i = v.e_iack; prev_da = v.d_a; prev_dd = v.d_dat;
      end
      v = nop(); v.r_v = 1; v.r_dat = 32'h1; v.e_irsp = 1; v.e_rdat = 32'h1;
      v.e_mv = 1; v.e_ma = 32'hA00; v.e_mrd = 4'hF;
      run(v, "starve_drain0");
      v = nop(); v.r_v = 1; v.r_dat = 32'h2; v.e_irsp = 1; v.e_rdat = 32'h2;
      run(v, "starve_drain1");

      // FIFO full: 4 D reads outstanding block a 5th; a write still goes; a pop lets the read in.
      for (int k = 0; k < 4; k++) begin
         v = nop();
         v.d_v = 1; v.d_a = 32'hC00 + 32'(k * 4); v.d_rd = 4'hF; v.e_dack = 1;
         v.e_mv = (k > 0); v.e_ma = 32'hC00 + 32'((k - 1) * 4); v.e_mrd = 4'hF;
         run(v, $sformatf("full_fill[%0d]", k));
      end
      v = nop(); v.d_v = 1; v.d_a = 32'hC10; v.d_rd = 4'hF;
      v.e_mv = 1; v.e_ma = 32'hC0C; v.e_mrd = 4'hF;
      run(v, "full_block");
      v = nop(); v.d_v = 1; v.d_a = 32'h200; v.d_dat = 32'h77; v.d_wr = 4'hF; v.e_dack = 1;
      run(v, "full_write");
      v = nop(); v.d_v = 1; v.d_a = 32'hC10; v.d_rd = 4'hF; v.e_dack = 1;
      v.r_v = 1; v.r_dat = 32'hD0; v.e_drsp = 1; v.e_rdat = 32'hD0;
      v.e_mv = 1; v.e_ma = 32'h200; v.e_md = 32'h77; v.e_mwr = 4'hF;
      run(v, "full_popgrant");
      for (int k = 0; k < 4; k++) begin
         v = nop(); v.r_v = 1; v.r_dat = 32'hD1 + 32'(k); v.e_drsp = 1; v.e_rdat = 32'hD1 + 32'(k);
         v.e_mv = (k == 0); v.e_ma = 32'hC10; v.e_mrd = 4'hF;
         run(v, $sformatf("full_drain[%0d]", k));
      end

      // Back-pressure: held request stays stable, no new ack until the port drains.
      v = nop(); v.d_v = 1; v.d_a = 32'h300; v.d_dat = 32'hABCD; v.d_wr = 4'hF; v.e_dack = 1;
      run(v, "stall0");
      for (int k = 0; k < 4; k++) begin
         v = nop(); v.d_v = 1; v.d_a = 32'h304; v.d_dat = 32'h1234; v.d_wr = 4'hF;
         v.m_rdy = (k == 3); v.e_dack = (k == 3);
         v.e_mv = 1; v.e_ma = 32'h300; v.e_md = 32'hABCD; v.e_mwr = 4'hF;
         run(v, $sformatf("stall_hold[%0d]", k));
      end
      v = nop(); v.e_mv = 1; v.e_ma = 32'h304; v.e_md = 32'h1234; v.e_mwr = 4'hF;
      run(v, "stall_next");
      run(nop(), "stall_idle");

      // Unexpected response, sticky flag, reset mid-stream, stale response, recovery.
      v = nop(); v.r_v = 1; v.r_dat = 32'hBAD;
      run(v, "unexp");
      v = nop(); v.e_err = 1;
      run(v, "unexp_sticky");
      v = nop(); v.i_v = 1; v.i_a = 32'h500; v.i_rd = 4'hF; v.e_iack = 1; v.e_err = 1;
      run(v, "pre_rst_rd");
      v = nop(); v.e_mv = 1; v.e_ma = 32'h500; v.e_mrd = 4'hF; v.e_err = 1;
      run(v, "pre_rst_port");
      @(negedge clk);
      rst_n = 1'b0;
      v = nop(); v.i_v = 1; v.i_a = 32'h504; v.i_rd = 4'hF; v.r_v = 1; v.r_dat = 32'h99;
      drive(v);
      #1;
      v.r_v = 0;
      v.i_v = 0;
      compare(nop(), "mid_rst");
      chk("mid_rst", "m_req_addr", m_req_addr, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(nop());
      #1;
      compare(nop(), "post_rst");
      v = nop(); v.r_v = 1; v.r_dat = 32'h5A5A;
      run(v, "stale_rsp");
      v = nop(); v.e_err = 1;
      run(v, "stale_flag");
      v = nop(); v.i_v = 1; v.i_a = 32'h600; v.i_rd = 4'hF; v.e_iack = 1; v.e_err = 1;
      run(v, "recover_rd");
      v = nop(); v.e_mv = 1; v.e_ma = 32'h600; v.e_mrd = 4'hF; v.e_err = 1;
      run(v, "recover_port");
      v = nop(); v.r_v = 1; v.r_dat = 32'hCAFEF00D; v.e_irsp = 1; v.e_rdat = 32'hCAFEF00D; v.e_err = 1;
      run(v, "recover_rsp");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
